serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial ripple-borrow subtractor: D = X - Y - Bi, DIGIT bits per cycle,
// least-significant digit first, with valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             borrow;
    logic [DIGIT-1:0] xd;
    logic [DIGIT-1:0] yd;
    logic [DIGIT:0]   diff;
    logic             last;
    logic             accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(N - 1));

    // Select the current digit of each latched operand.
    always_comb begin
        xd = '0;
        yd = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                xd = xr[i*DIGIT +: DIGIT];
                yd = yr[i*DIGIT +: DIGIT];
            end
        end
    end

    // The extra top bit of diff is the borrow into the next digit.
    assign diff = {1'b0, xd} - {1'b0, yd} - {{DIGIT{1'b0}}, borrow};

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (accept) next = RUN;
            RUN:     if (last) next = DONE;
            DONE:    if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            xr     <= '0;
            yr     <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bo     <= 1'b0;
            V      <= 1'b0;
        end else begin
            state <= next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        xr     <= X;
                        yr     <= Y;
                        borrow <= Bi;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (cnt == CW'(i)) D[i*DIGIT +: DIGIT] <= diff[DIGIT-1:0];
                    end
                    borrow <= diff[DIGIT];
                    cnt    <= last ? '0 : cnt + 1'b1;
                    // The last digit carries the result MSB.
                    if (last) begin
                        Bo <= diff[DIGIT];
                        V  <= (xr[WIDTH-1] ^ yr[WIDTH-1]) &
                              (diff[DIGIT-1] ^ xr[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vectors, handshake corner cases and
// a random sweep over DIGIT = 4, 1, 8, 32 against an arithmetic reference.
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [31:0] X         [4];
    logic [31:0] Y         [4];
    logic        Bi        [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [31:0] D         [4];
    logic        Bo        [4];
    logic        V         [4];

    int asserts  = 0;
    int failures = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_subtractor #(
            .WIDTH(32),
            .DIGIT(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 8 : 32)
        ) dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .X(X[g]),
            .Y(Y[g]),
            .Bi(Bi[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .D(D[g]),
            .Bo(Bo[g]),
            .V(V[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the whole operands.
    task automatic model(input logic [31:0] x, input logic [31:0] y,
                         input logic bi, output logic [31:0] d,
                         output logic bo, output logic v);
        longint r;
        r  = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        d  = r[31:0];
        bo = ({32'b0, x} < ({32'b0, y} + 64'(bi)));
        v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic start_op(input int j, input logic [31:0] x,
                            input logic [31:0] y, input logic bi);
        int n = 0;
        while (!in_ready[j] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready[j]), 64'd1);
        X[j] = x;
        Y[j] = y;
        Bi[j] = bi;
        in_valid[j] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[j] = 1'b0;
        chk("in_ready_low_after_accept", 64'(in_ready[j]), 64'd0);
    endtask

    task automatic wait_done(input int j, output int lat);
        lat = 0;
        while (!out_valid[j] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid[j]) begin
            failures++;
            $display("FAIL timeout waiting for out_valid on dut %0d", j);
        end
    endtask

    task automatic release_out(input int j);
        out_ready[j] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[j] = 1'b0;
        chk("out_valid_low_after_release", 64'(out_valid[j]), 64'd0);
        chk("in_ready_high_after_release", 64'(in_ready[j]), 64'd1);
    endtask

    task automatic do_op(input int j, input int n, input logic [31:0] x,
                         input logic [31:0] y, input logic bi,
                         input logic [31:0] ed, input logic ebo,
                         input logic ev);
        int lat;
        start_op(j, x, y, bi);
        wait_done(j, lat);
        chk("latency", 64'(lat), 64'(n));
        chk("D", 64'(D[j]), 64'(ed));
        chk("Bo", 64'(Bo[j]), 64'(ebo));
        chk("V", 64'(V[j]), 64'(ev));
        release_out(j);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        v;
    } vec_t;

    vec_t vt[6];

    initial begin
        int          lat;
        logic [31:0] x, y, ed;
        logic        bi, ebo, ev;
        int          nd[4];

        vt[0] = '{32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0};
        vt[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vt[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        nd[0] = 8;
        nd[1] = 32;
        nd[2] = 4;
        nd[3] = 1;

        rst = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid[j]  = 1'b0;
            out_ready[j] = 1'b0;
            X[j] = '0;
            Y[j] = '0;
            Bi[j] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_D", 64'(D[0]), 64'd0);
        chk("rst_Bo", 64'(Bo[0]), 64'd0);
        chk("rst_V", 64'(V[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready[0]), 64'd1);

        for (int i = 0; i < 6; i++)
            do_op(0, 8, vt[i].x, vt[i].y, vt[i].bi, vt[i].d, vt[i].bo, vt[i].v);

        // Backpressure: result held while operands and in_valid wiggle.
        start_op(0, 32'h10, 32'h1, 1'b0);
        wait_done(0, lat);
        chk("bp_latency", 64'(lat), 64'd8);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            X[0] = $urandom;
            Y[0] = $urandom;
            in_valid[0] = c[0];
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
            chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_D", 64'(D[0]), 64'h0000_000F);
            chk("bp_Bo", 64'(Bo[0]), 64'd0);
            chk("bp_V", 64'(V[0]), 64'd0);
        end
        in_valid[0] = 1'b0;
        release_out(0);

        // Reset on the 4th RUN edge abandons the operation.
        start_op(0, 32'h1234_5678, 32'h0000_1111, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("midrun_rst_D", 64'(D[0]), 64'd0);
        chk("midrun_rst_Bo", 64'(Bo[0]), 64'd0);
        chk("midrun_rst_V", 64'(V[0]), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_midrun_rst", 64'(in_ready[0]), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("no_out_valid_after_rst", 64'(out_valid[0]), 64'd0);
        end
        do_op(0, 8, 32'd100, 32'd58, 1'b0, 32'd42, 1'b0, 1'b0);

        // Random sweep on every digit size.
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 1000; k++) begin
                x  = $urandom;
                y  = $urandom;
                bi = 1'($urandom_range(1, 0));
                if (k < 4) begin
                    x = (k[0]) ? 32'hFFFF_FFFF : 32'h0;
                    y = (k[1]) ? 32'hFFFF_FFFF : 32'h0;
                end
                model(x, y, bi, ed, ebo, ev);
                do_op(j, nd[j], x, y, bi, ed, ebo, ev);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, failures);
        $finish;
    end

endmodule
